// File: rtl/data_store_pkg.sv
// Shared types for the data store sequencer: size codes, FSM states and beat count.
package data_store_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        RESP  = 2'b10
    } state_e;

    function automatic logic [2:0] beat_count(input size_e sz);
        case (sz)
            SZ_BYTE: beat_count = 3'd1;
            SZ_HALF: beat_count = 3'd2;
            SZ_WORD: beat_count = 3'd4;
            default: beat_count = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/data_store_unit_lane_sel.sv
// Big-endian byte lane selector: beat 0 carries the most significant byte of the quantity.
module store_lane_sel
    import data_store_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  beat,
    input  logic [31:0] data,
    output logic [7:0]  lane
);

    always_comb begin
        lane = '0;
        case (size)
            SZ_WORD: begin
                case (beat)
                    2'd0:    lane = data[31:24];
                    2'd1:    lane = data[23:16];
                    2'd2:    lane = data[15:8];
                    default: lane = data[7:0];
                endcase
            end
            SZ_HALF: lane = beat[0] ? data[7:0] : data[15:8];
            SZ_BYTE: lane = data[7:0];
            default: lane = '0;
        endcase
    end

endmodule

// File: rtl/data_store_unit.sv
// Write-side sequencer: serialises one byte/half/word store into single-byte RAM beats.
// Optional alignment rejection is enabled by defining DATA_STORE_ALIGN_CHECK_EN.
module data_store_unit
    import data_store_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int RESP_PULSE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              done,
    output logic              err
);

    localparam int unused_resp_pulse = RESP_PULSE;

    state_e      state, state_n;
    size_e       lat_size;
    logic [31:0] lat_data;
    logic [1:0]  cnt;
    size_e       in_size;
    logic        accept, misalign, reject, last;
    size_e       sel_size;
    logic [1:0]  sel_beat;
    logic [31:0] sel_data;
    logic [7:0]  lane;
    logic        done_n, err_n;

    assign in_size = size_e'(req_size);

`ifdef DATA_STORE_ALIGN_CHECK_EN
    assign misalign = ((in_size == SZ_HALF) && req_addr[0]) ||
                      ((in_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign accept = req_valid && (state == IDLE);
    assign reject = (in_size == SZ_RSVD) || misalign;
    assign last   = ({1'b0, cnt} == (beat_count(lat_size) - 3'd1));

    generate
        if (ADDR_W < 32) begin : g_addr_unused
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[31:ADDR_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = reject ? RESP : WRITE;
            WRITE:   if (last)   state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The first beat is launched from the live request on the accepting edge,
    // later beats from the latched copy, so one lane selector serves both.
    always_comb begin
        req_ready = (state == IDLE);
        sel_size  = (state == IDLE) ? in_size  : lat_size;
        sel_data  = (state == IDLE) ? req_data : lat_data;
        sel_beat  = (state == IDLE) ? 2'd0     : cnt + 2'd1;
        done_n    = (state_n == RESP);
        err_n     = accept && reject;
    end

    store_lane_sel u_lane_sel (
        .size (sel_size),
        .beat (sel_beat),
        .data (sel_data),
        .lane (lane)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_size  <= SZ_BYTE;
            lat_data  <= '0;
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= done_n;
            err  <= err_n;
            if (accept) begin
                lat_size <= in_size;
                lat_data <= req_data;
                cnt      <= '0;
                mem_we   <= !reject;
                if (!reject) begin
                    mem_addr  <= req_addr[ADDR_W-1:0];
                    mem_wdata <= lane;
                end
            end else if ((state == WRITE) && !last) begin
                cnt       <= cnt + 2'd1;
                mem_we    <= 1'b1;
                mem_addr  <= mem_addr + ADDR_W'(1);
                mem_wdata <= lane;
            end else begin
                mem_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_store_unit.sv
// Self-checking bench for data_store_unit: directed table, corner sequences, random vs. model.
module tb_data_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        done;
    logic        err;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    data_store_unit #(.ADDR_W(16), .RESP_PULSE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        int          nbeats;
        int          lat;
        bit          err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic bit model_reject(logic [31:0] a, logic [1:0] s);
        if (s == 2'b11) return 1'b1;
`ifdef DATA_STORE_ALIGN_CHECK_EN
        if (s == 2'b01 && a[0]) return 1'b1;
        if (s == 2'b10 && a[1:0] != 2'b00) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic int model_n(logic [31:0] a, logic [1:0] s);
        if (model_reject(a, s)) return 0;
        return 1 << s;
    endfunction

    function automatic logic [7:0] model_byte(logic [31:0] d, int n, int k);
        return 8'(d >> (8 * (n - 1 - k)));
    endfunction

    function automatic logic [15:0] model_addr(logic [31:0] a, int k);
        return 16'((a + 32'(k)) % 32'h10000);
    endfunction

    task automatic run_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                           input int exp_n, input int exp_lat, input bit exp_err);
        int nb = 0;
        int lat = -1;
        logic got_err = 1'b0;
        bit busy_ok = 1'b1;
        logic [15:0] ba [8];
        logic [7:0]  bd [8];
        @(negedge clk);
        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_data = $urandom; req_size = 2'($urandom);
        for (int c = 1; c <= 10 && lat < 0; c++) begin
            if (mem_we) begin
                if (nb < 8) begin ba[nb] = mem_addr; bd[nb] = mem_wdata; end
                nb++;
            end
            if (req_ready) busy_ok = 1'b0;
            if (done) begin lat = c; got_err = err; end
            @(posedge clk); #1;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("err", 32'(got_err), 32'(exp_err));
        chk("nbeats", 32'(nb), 32'(exp_n));
        chk("ready_busy_low", 32'(busy_ok), 32'd1);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("ready_after", 32'(req_ready), 32'd1);
        for (int k = 0; k < exp_n && k < nb && k < 8; k++) begin
            chk("beat_addr", 32'(ba[k]), 32'(model_addr(a, k)));
            chk("beat_data", 32'(bd[k]), 32'(model_byte(d, exp_n, k)));
        end
    endtask

    vec_t vecs [6];

    initial begin
        logic [31:0] ra, rd;
        logic [1:0]  rs;
        int          rn;
        bit          saw_done;
        logic        we_at [14];
        logic [15:0] ad_at [14];
        logic [7:0]  wd_at [14];
        logic        dn_at [14];

        vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 2'b10, 4, 5, 1'b0};
        vecs[1] = '{32'h0000_0020, 32'h1234_ABCD, 2'b01, 2, 3, 1'b0};
        vecs[2] = '{32'h0000_0031, 32'hFFFF_FF5A, 2'b00, 1, 2, 1'b0};
`ifdef DATA_STORE_ALIGN_CHECK_EN
        vecs[3] = '{32'h0000_FFFE, 32'h0102_0304, 2'b10, 0, 1, 1'b1};
        vecs[4] = '{32'h0000_0041, 32'h0000_7788, 2'b01, 0, 1, 1'b1};
`else
        vecs[3] = '{32'h0000_FFFE, 32'h0102_0304, 2'b10, 4, 5, 1'b0};
        vecs[4] = '{32'h0000_0041, 32'h0000_7788, 2'b01, 2, 3, 1'b0};
`endif
        vecs[5] = '{32'h0000_0050, 32'hCAFE_F00D, 2'b11, 0, 1, 1'b1};

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
        #12;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_req(vecs[i].addr, vecs[i].data, vecs[i].size,
                    vecs[i].nbeats, vecs[i].lat, vecs[i].err);

        // Reset during beat 2 of a word store.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0100; req_data = 32'hA1B2_C3D4; req_size = 2'b10;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_beat2_addr", 32'(mem_addr), 32'h0102);
        chk("mid_beat2_we", 32'(mem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (done || mem_we) saw_done = 1'b1;
        end
        chk("post_rst_quiet", 32'(saw_done), 32'd0);
        run_req(32'h0000_0200, 32'h5566_7788, 2'b10, 4, 5, 1'b0);

        // Back-to-back: valid held high, second request taken on first IDLE cycle after RESP.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0300; req_data = 32'h1122_3344; req_size = 2'b10;
        @(posedge clk); #1;
        req_addr = 32'h0000_0400; req_data = 32'h5566_7788;
        for (int c = 1; c < 14; c++) begin
            we_at[c] = mem_we; ad_at[c] = mem_addr; wd_at[c] = mem_wdata; dn_at[c] = done;
            if (c == 6) chk("b2b_ready_c6", 32'(req_ready), 32'd1);
            if (c == 7) req_valid = 1'b0;
            @(posedge clk); #1;
        end
        for (int c = 1; c < 14; c++) begin
            chk("b2b_we", 32'(we_at[c]), 32'((c >= 1 && c <= 4) || (c >= 7 && c <= 10)));
            chk("b2b_done", 32'(dn_at[c]), 32'(c == 5 || c == 11));
            if (c >= 1 && c <= 4) begin
                chk("b2b_a_addr", 32'(ad_at[c]), 32'(model_addr(32'h300, c - 1)));
                chk("b2b_a_data", 32'(wd_at[c]), 32'(model_byte(32'h1122_3344, 4, c - 1)));
            end
            if (c >= 7 && c <= 10) begin
                chk("b2b_b_addr", 32'(ad_at[c]), 32'(model_addr(32'h400, c - 7)));
                chk("b2b_b_data", 32'(wd_at[c]), 32'(model_byte(32'h5566_7788, 4, c - 7)));
            end
        end

        for (int i = 0; i < 40; i++) begin
            rs = 2'($urandom_range(0, 3));
            rd = $urandom;
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) ra[15:0] = 16'hFFFC + 16'($urandom_range(0, 3));
            rn = model_n(ra, rs);
            run_req(ra, rd, rs, rn, (rn == 0) ? 1 : rn + 1, model_reject(ra, rs));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
